// File: rtl/io_arbiter.sv
// Two-master IO bus arbiter and sequencer: each access runs IDLE -> ISSUE -> CAPTURE -> DONE.
// Define IO_ARB_ROUND_ROBIN_EN for round-robin arbitration; the default build gives master 0 fixed priority.
module io_arbiter #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              m0_req,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   input  logic              m0_write,
   output logic              m0_ack,
   output logic [DATA_W-1:0] m0_rdata,
   input  logic              m1_req,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   input  logic              m1_write,
   output logic              m1_ack,
   output logic [DATA_W-1:0] m1_rdata,
   output logic [ADDR_W-1:0] io_addr,
   output logic [DATA_W-1:0] io_data,
   output logic              io_write,
   input  logic [DATA_W-1:0] io_rdata,
   output logic              busy,
   output logic              grant
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_ISSUE   = 2'd1;
   localparam logic [1:0] S_CAPTURE = 2'd2;
   localparam logic [1:0] S_DONE    = 2'd3;

   logic [1:0]        state_q,    state_d;
   logic [ADDR_W-1:0] io_addr_q,  io_addr_d;
   logic [DATA_W-1:0] io_data_q,  io_data_d;
   logic              write_q,    write_d;
   logic              grant_q,    grant_d;
   logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
   logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;
   logic              winner;

`ifdef IO_ARB_ROUND_ROBIN_EN
   // prio_q names the master that wins the next tie; it flips away from every winner.
   logic prio_q, prio_d;

   always_comb begin
      if (m0_req && m1_req) winner = prio_q;
      else                  winner = !m0_req;
   end
`else
   always_comb begin
      winner = !m0_req;
   end
`endif

   always_comb begin
      // NOTE: every next-state signal starts from its register value, so no path through this block can infer a latch.
      state_d    = state_q;
      io_addr_d  = io_addr_q;
      io_data_d  = io_data_q;
      write_d    = write_q;
      grant_d    = grant_q;
      m0_rdata_d = m0_rdata_q;
      m1_rdata_d = m1_rdata_q;
`ifdef IO_ARB_ROUND_ROBIN_EN
      prio_d     = prio_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (m0_req || m1_req) begin
               grant_d   = winner;
               io_addr_d = winner ? m1_addr  : m0_addr;
               io_data_d = winner ? m1_wdata : m0_wdata;
               write_d   = winner ? m1_write : m0_write;
`ifdef IO_ARB_ROUND_ROBIN_EN
               prio_d    = !winner;
`endif
               state_d   = S_ISSUE;
            end
         end
         S_ISSUE: state_d = S_CAPTURE;
         S_CAPTURE: begin
            // The IO block's registered read data is valid only in this cycle.
            if (!write_q) begin
               if (grant_q) m1_rdata_d = io_rdata;
               else         m0_rdata_d = io_rdata;
            end
            state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: state is updated only with non-blocking assignments so every register sees pre-edge values.
      if (rst) begin
         state_q    <= S_IDLE;
         io_addr_q  <= '0;
         io_data_q  <= '0;
         write_q    <= 1'b0;
         grant_q    <= 1'b0;
         m0_rdata_q <= '0;
         m1_rdata_q <= '0;
`ifdef IO_ARB_ROUND_ROBIN_EN
         prio_q     <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         io_addr_q  <= io_addr_d;
         io_data_q  <= io_data_d;
         write_q    <= write_d;
         grant_q    <= grant_d;
         m0_rdata_q <= m0_rdata_d;
         m1_rdata_q <= m1_rdata_d;
`ifdef IO_ARB_ROUND_ROBIN_EN
         prio_q     <= prio_d;
`endif
      end
   end

   // Strobe and acks decode straight from the state so each lasts exactly one cycle.
   assign io_write = (state_q == S_ISSUE) && write_q;
   assign m0_ack   = (state_q == S_DONE) && !grant_q;
   assign m1_ack   = (state_q == S_DONE) &&  grant_q;
   assign busy     = (state_q != S_IDLE);
   assign grant    = grant_q;
   assign io_addr  = io_addr_q;
   assign io_data  = io_data_q;
   assign m0_rdata = m0_rdata_q;
   assign m1_rdata = m1_rdata_q;

endmodule

// File: tb/tb_io_arbiter.sv
// Directed bench for io_arbiter with a small IO block model (LED at addr 0 write, button/switch reads).
// Expectations for the contention sequence follow IO_ARB_ROUND_ROBIN_EN when it is defined.
module tb_io_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        m0_req, m0_write, m0_ack;
   logic [15:0] m0_addr, m0_wdata, m0_rdata;
   logic        m1_req, m1_write, m1_ack;
   logic [15:0] m1_addr, m1_wdata, m1_rdata;
   logic [15:0] io_addr, io_data, io_rdata;
   logic        io_write, busy, grant;

   logic [3:0]  sw = 4'h0;
   logic        btn = 1'b0;
   logic [7:0]  led = 8'h00;
   logic [15:0] io_rdata_m = 16'h0000;

   int checks = 0;
   int failures = 0;

   typedef struct {
      string       name;
      bit          m;
      bit          wr;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [3:0]  sw;
      bit          btn;
      logic [15:0] exp_m0;
      logic [15:0] exp_m1;
      logic [7:0]  exp_led;
   } vec_t;

   vec_t vecs[6];

   io_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_write(m0_write),
      .m0_ack(m0_ack), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_write(m1_write),
      .m1_ack(m1_ack), .m1_rdata(m1_rdata),
      .io_addr(io_addr), .io_data(io_data), .io_write(io_write), .io_rdata(io_rdata),
      .busy(busy), .grant(grant)
   );

   always #5 clk = ~clk;

   // IO block model: no reset, one-cycle registered read, unmapped reads keep stale data.
   always @(posedge clk) begin
      if (io_write && io_addr == 16'h0000) led <= io_data[7:0];
      case (io_addr)
         16'h0000: io_rdata_m <= {btn, 15'b0};
         16'h0001: io_rdata_m <= {sw, 12'b0};
         default:  ;
      endcase
   end
   assign io_rdata = io_rdata_m;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, " io_addr"}, io_addr, 16'h0000);
      check({tag, " io_data"}, io_data, 16'h0000);
      check({tag, " status"}, {busy, io_write, m0_ack, m1_ack, grant}, 5'b00000);
      check({tag, " m0_rdata"}, m0_rdata, 16'h0000);
      check({tag, " m1_rdata"}, m1_rdata, 16'h0000);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
   endtask

   // Runs one single-master transaction starting at a cycle boundary with the FSM idle.
   task automatic run_vec(input vec_t v);
      logic [3:0] exp;
      sw  = v.sw;
      btn = v.btn;
      if (v.m) begin
         m1_addr = v.addr; m1_wdata = v.wdata; m1_write = v.wr; m1_req = 1'b1;
      end else begin
         m0_addr = v.addr; m0_wdata = v.wdata; m0_write = v.wr; m0_req = 1'b1;
      end
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         exp = {(c >= 1 && c <= 3), (v.wr && c == 1), (!v.m && c == 3), (v.m && c == 3)};
         check($sformatf("%s status c%0d", v.name, c), {busy, io_write, m0_ack, m1_ack}, exp);
         if (c == 1) begin
            check({v.name, " io_addr"}, io_addr, v.addr);
            check({v.name, " io_data"}, io_data, v.wdata);
            check({v.name, " grant"}, grant, v.m);
         end
         if (c == 2) check({v.name, " led"}, led, v.exp_led);
         if (c == 3) begin
            check({v.name, " m0_rdata"}, m0_rdata, v.exp_m0);
            check({v.name, " m1_rdata"}, m1_rdata, v.exp_m1);
         end
         next_cycle();
         if (c == 3) begin
            m0_req = 1'b0;
            m1_req = 1'b0;
         end
      end
   endtask

   initial begin
      logic [15:0] m0_mask, m1_mask;
      bit          rr;
      bit          m1_acked;

      vecs[0] = '{"m0_rd_sw",       1'b0, 1'b0, 16'h0001, 16'h1111, 4'hA, 1'b0, 16'hA000, 16'h0000, 8'h00};
      vecs[1] = '{"m1_wr_led",      1'b1, 1'b1, 16'h0000, 16'h00A5, 4'hA, 1'b0, 16'hA000, 16'h0000, 8'hA5};
      vecs[2] = '{"m1_rd_btn",      1'b1, 1'b0, 16'h0000, 16'h0000, 4'hA, 1'b1, 16'hA000, 16'h8000, 8'hA5};
      vecs[3] = '{"m0_wr_led",      1'b0, 1'b1, 16'h0000, 16'h1234, 4'hA, 1'b1, 16'hA000, 16'h8000, 8'h34};
      vecs[4] = '{"m0_rd_unmapped", 1'b0, 1'b0, 16'h0007, 16'h0000, 4'hA, 1'b1, 16'h8000, 16'h8000, 8'h34};
      vecs[5] = '{"m1_rd_sw",       1'b1, 1'b0, 16'h0001, 16'h0000, 4'h5, 1'b1, 16'h8000, 16'h5000, 8'h34};

      rst = 1'b1;
      m0_req = 1'b0; m0_addr = '0; m0_wdata = '0; m0_write = 1'b0;
      m1_req = 1'b0; m1_addr = '0; m1_wdata = '0; m1_write = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check_reset_state("reset");
      next_cycle();

      foreach (vecs[i]) run_vec(vecs[i]);

      // Reset pulsed during CAPTURE of an m0 read abandons it without an ack.
      sw = 4'h3;
      m0_addr = 16'h0001; m0_wdata = 16'h0000; m0_write = 1'b0; m0_req = 1'b1;
      next_cycle();
      next_cycle();
      rst = 1'b1;
      @(negedge clk);
      check("rst_mid capture status", {busy, io_write, m0_ack, m1_ack}, 4'b1000);
      next_cycle();
      rst = 1'b0;
      m0_req = 1'b0;
      @(negedge clk);
      check_reset_state("rst_mid after");
      next_cycle();
      @(negedge clk);
      check("rst_mid no late ack", {busy, m0_ack, m1_ack}, 3'b000);
      next_cycle();
      run_vec('{"rst_mid m1_rd_btn", 1'b1, 1'b0, 16'h0000, 16'h0000, 4'h3, 1'b1, 16'h0000, 16'h8000, 8'h34});

      // Back-to-back reads with m0 holding req across both.
      sw = 4'hC;
      m0_addr = 16'h0001; m0_wdata = 16'h0000; m0_write = 1'b0; m0_req = 1'b1;
      for (int c = 0; c < 9; c++) begin
         @(negedge clk);
         check($sformatf("b2b status c%0d", c), {busy, m0_ack, m1_ack},
               {(c != 0 && c != 4 && c != 8), (c == 3 || c == 7), 1'b0});
         if (c == 3) check("b2b first rdata", m0_rdata, 16'hC000);
         if (c == 7) check("b2b second rdata", m0_rdata, 16'h6000);
         next_cycle();
         if (c == 4) sw = 4'h6;
         if (c == 7) m0_req = 1'b0;
      end

      // Contention: both request in cycle 0, m0 keeps requesting, m1 drops after its ack.
`ifdef IO_ARB_ROUND_ROBIN_EN
      rr = 1'b1;
      m0_mask = 16'b1000_1000_0000_1000;
      m1_mask = 16'b0000_0000_1000_0000;
`else
      rr = 1'b0;
      m0_mask = 16'b1000_1000_1000_1000;
      m1_mask = 16'b0000_0000_0000_0000;
`endif
      do_reset();
      sw = 4'hA; btn = 1'b1;
      m0_addr = 16'h0001; m0_write = 1'b0; m0_req = 1'b1;
      m1_addr = 16'h0000; m1_write = 1'b0; m1_req = 1'b1;
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         m1_acked = m1_ack;
         check($sformatf("contend c%0d", c), {m0_ack, m1_ack, grant},
               {m0_mask[c], m1_mask[c], (rr && c >= 5 && c <= 8)});
         if (c == 3) check("contend m0 rdata", m0_rdata, 16'hA000);
         next_cycle();
         if (m1_acked) m1_req = 1'b0;
      end
      m0_req = 1'b0;
      m1_req = 1'b0;
      check("contend m1 rdata", m1_rdata, rr ? 16'h8000 : 16'h0000);
      repeat (4) next_cycle();
      @(negedge clk);
      check("final idle", {busy, m0_ack, m1_ack}, 3'b000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
